commit_trace_packer: RTL and testbench

Producer side of the commit-trace co-simulation interface. It captures per-cycle retire and trap events from the core pipeline and buffers them in an ordered FIFO. It emits them as packed beats of up to COMMIT_WIDTH commits on the lane-parallel trace bus consumed by the Dromajo step checker. Trap events are serialized against commits so the checker always sees a trap after every older commit.

---
 rtl/commit_trace_packer.sv | 184 ++++++++++++++++++
 tb/tb_commit_trace_packer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_packer.sv
// Commit-trace packer: queues retire/trap events and emits lane-packed beats for the step checker.
// Optional DIFFTEST_TRACE_STALL_EN adds a core_stall output raised when the FIFO nears full.
module commit_trace_packer #(
    parameter int COMMIT_WIDTH = 2,
    parameter int XLEN         = 64,
    parameter int INST_BITS    = 32,
    parameter int HARTID_LEN   = 1,
    parameter int DEPTH        = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [XLEN-1:0]               in_pc,
    input  logic [INST_BITS-1:0]          in_inst,
    input  logic [XLEN-1:0]               in_wdata,
    input  logic [XLEN-1:0]               in_mstatus,
    input  logic                          in_check,
    input  logic                          in_trap,
    input  logic [XLEN-1:0]               in_cause,
    input  logic [HARTID_LEN-1:0]         in_hartid,
    input  logic                          drain_en,
    output logic [COMMIT_WIDTH-1:0]       valid,
    output logic [HARTID_LEN-1:0]         hartid,
    output logic [COMMIT_WIDTH*XLEN-1:0]  pc,
    output logic [COMMIT_WIDTH*INST_BITS-1:0] inst,
    output logic [COMMIT_WIDTH*XLEN-1:0]  wdata,
    output logic [COMMIT_WIDTH*XLEN-1:0]  mstatus,
    output logic [COMMIT_WIDTH-1:0]       check,
    output logic                          int_xcpt,
    output logic [XLEN-1:0]               cause,
    output logic                          overflow,
    output logic [$clog2(DEPTH):0]        count
`ifdef DIFFTEST_TRACE_STALL_EN
    ,
    output logic                          core_stall
`endif
);

    localparam int AW   = $clog2(DEPTH);
    localparam int PTRW = AW + 1;

    typedef enum logic {KIND_COMMIT = 1'b0, KIND_TRAP = 1'b1} kind_e;

    kind_e                kind_mem    [DEPTH];
    logic [XLEN-1:0]      pc_mem      [DEPTH];
    logic [INST_BITS-1:0] inst_mem    [DEPTH];
    logic [XLEN-1:0]      wdata_mem   [DEPTH];
    logic [XLEN-1:0]      mstatus_mem [DEPTH];
    logic                 check_mem   [DEPTH];
    logic [XLEN-1:0]      cause_mem   [DEPTH];

    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic [PTRW-1:0] need, free_slots, push_cnt, pop_cnt;
    logic            admit, overflow_q, overflow_d, blocked;
    logic [AW-1:0]   wr_idx, trap_idx;
    logic [AW-1:0]   lane_idx [COMMIT_WIDTH];

    logic [COMMIT_WIDTH-1:0]           valid_q, valid_d, check_q, check_d;
    logic [COMMIT_WIDTH*XLEN-1:0]      pc_q, pc_d, wdata_q, wdata_d, mstatus_q, mstatus_d;
    logic [COMMIT_WIDTH*INST_BITS-1:0] inst_q, inst_d;
    logic                              int_xcpt_q, int_xcpt_d;
    logic [XLEN-1:0]                   cause_q, cause_d;
    logic [HARTID_LEN-1:0]             hartid_q;

    // Admission is judged against pre-pop occupancy, so a push never lands in a slot being popped.
    always_comb begin
        need       = PTRW'(in_valid) + PTRW'(in_trap);
        free_slots = PTRW'(DEPTH) - count_q;
        admit      = (need <= free_slots);
        push_cnt   = admit ? need : '0;
        overflow_d = overflow_q | ~admit;
        wr_idx     = wr_ptr_q[AW-1:0];
        trap_idx   = wr_idx + AW'(in_valid);
        wr_ptr_d   = wr_ptr_q + push_cnt;
        rd_ptr_d   = rd_ptr_q + pop_cnt;
        count_d    = count_q + push_cnt - pop_cnt;
    end

    always_comb begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            lane_idx[i] = rd_ptr_q[AW-1:0] + AW'(i);
        end
    end

    // A trap at the head goes out alone; otherwise pack commits from the head up to the next trap.
    always_comb begin
        pop_cnt    = '0;
        blocked    = 1'b0;
        valid_d    = '0;
        check_d    = '0;
        pc_d       = '0;
        inst_d     = '0;
        wdata_d    = '0;
        mstatus_d  = '0;
        int_xcpt_d = 1'b0;
        cause_d    = '0;
        if (drain_en && count_q != '0) begin
            if (kind_mem[lane_idx[0]] == KIND_TRAP) begin
                int_xcpt_d = 1'b1;
                cause_d    = cause_mem[lane_idx[0]];
                pop_cnt    = PTRW'(1);
            end else begin
                for (int i = 0; i < COMMIT_WIDTH; i++) begin
                    if (!blocked && PTRW'(i) < count_q && kind_mem[lane_idx[i]] == KIND_COMMIT) begin
                        valid_d[i]                        = 1'b1;
                        check_d[i]                        = check_mem[lane_idx[i]];
                        pc_d[i*XLEN +: XLEN]              = pc_mem[lane_idx[i]];
                        inst_d[i*INST_BITS +: INST_BITS]  = inst_mem[lane_idx[i]];
                        wdata_d[i*XLEN +: XLEN]           = wdata_mem[lane_idx[i]];
                        mstatus_d[i*XLEN +: XLEN]         = mstatus_mem[lane_idx[i]];
                        pop_cnt                           = pop_cnt + PTRW'(1);
                    end else begin
                        blocked = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (admit && in_valid) begin
            kind_mem[wr_idx]    <= KIND_COMMIT;
            pc_mem[wr_idx]      <= in_pc;
            inst_mem[wr_idx]    <= in_inst;
            wdata_mem[wr_idx]   <= in_wdata;
            mstatus_mem[wr_idx] <= in_mstatus;
            check_mem[wr_idx]   <= in_check;
        end
        if (admit && in_trap) begin
            kind_mem[trap_idx]  <= KIND_TRAP;
            cause_mem[trap_idx] <= in_cause;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= '0;
            check_q    <= '0;
            pc_q       <= '0;
            inst_q     <= '0;
            wdata_q    <= '0;
            mstatus_q  <= '0;
            int_xcpt_q <= 1'b0;
            cause_q    <= '0;
            hartid_q   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            check_q    <= check_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            wdata_q    <= wdata_d;
            mstatus_q  <= mstatus_d;
            int_xcpt_q <= int_xcpt_d;
            cause_q    <= cause_d;
            hartid_q   <= in_hartid;
        end
    end

    assign valid    = valid_q;
    assign check    = check_q;
    assign pc       = pc_q;
    assign inst     = inst_q;
    assign wdata    = wdata_q;
    assign mstatus  = mstatus_q;
    assign int_xcpt = int_xcpt_q;
    assign cause    = cause_q;
    assign hartid   = hartid_q;
    assign overflow = overflow_q;
    assign count    = count_q;

`ifdef DIFFTEST_TRACE_STALL_EN
    // Threshold leaves room for two pushes while the core reacts to the stall.
    assign core_stall = (count_q >= PTRW'(DEPTH - 3));
`endif

endmodule

// File: tb/tb_commit_trace_packer.sv
// Testbench for commit_trace_packer: directed scenarios plus random traffic against a queue-based model.
module tb_commit_trace_packer;

    localparam int CW    = 2;
    localparam int XLEN  = 64;
    localparam int IB    = 32;
    localparam int HL    = 1;
    localparam int DEPTH = 8;
    localparam int PW    = $clog2(DEPTH) + 1;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                in_valid = 1'b0;
    logic [XLEN-1:0]     in_pc = '0;
    logic [IB-1:0]       in_inst = '0;
    logic [XLEN-1:0]     in_wdata = '0;
    logic [XLEN-1:0]     in_mstatus = '0;
    logic                in_check = 1'b0;
    logic                in_trap = 1'b0;
    logic [XLEN-1:0]     in_cause = '0;
    logic [HL-1:0]       in_hartid = '0;
    logic                drain_en = 1'b0;
    logic [CW-1:0]       valid;
    logic [HL-1:0]       hartid;
    logic [CW*XLEN-1:0]  pc, wdata, mstatus;
    logic [CW*IB-1:0]    inst;
    logic [CW-1:0]       check;
    logic                int_xcpt;
    logic [XLEN-1:0]     cause;
    logic                overflow;
    logic [PW-1:0]       count;
`ifdef DIFFTEST_TRACE_STALL_EN
    logic                core_stall;
`endif

    commit_trace_packer #(
        .COMMIT_WIDTH(CW), .XLEN(XLEN), .INST_BITS(IB), .HARTID_LEN(HL), .DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_wdata(in_wdata),
        .in_mstatus(in_mstatus), .in_check(in_check), .in_trap(in_trap), .in_cause(in_cause),
        .in_hartid(in_hartid), .drain_en(drain_en),
        .valid(valid), .hartid(hartid), .pc(pc), .inst(inst), .wdata(wdata), .mstatus(mstatus),
        .check(check), .int_xcpt(int_xcpt), .cause(cause), .overflow(overflow), .count(count)
`ifdef DIFFTEST_TRACE_STALL_EN
        , .core_stall(core_stall)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        bit              trap;
        logic [XLEN-1:0] pc;
        logic [IB-1:0]   inst;
        logic [XLEN-1:0] wdata;
        logic [XLEN-1:0] mstatus;
        logic            chk;
        logic [XLEN-1:0] cause;
    } ev_t;

    ev_t q[$];
    int  vectors = 0;
    int  miscompares = 0;

    logic [CW-1:0]       expValid, expCheck;
    logic [CW*XLEN-1:0]  expPc, expWdata, expMstatus;
    logic [CW*IB-1:0]    expInst;
    logic                expXcpt, expOverflow;
    logic [XLEN-1:0]     expCause;
    logic [HL-1:0]       expHart;

    task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearBeat();
        expValid = '0; expCheck = '0; expPc = '0; expWdata = '0; expMstatus = '0;
        expInst = '0; expXcpt = 1'b0; expCause = '0;
    endtask

    task automatic modelReset();
        q.delete();
        clearBeat();
        expOverflow = 1'b0;
        expHart = '0;
    endtask

    // Reference: emit from the pre-push queue, then admit this cycle's events all-or-nothing.
    task automatic modelStep();
        int  pre;
        int  needed;
        ev_t e;
        pre = q.size();
        clearBeat();
        if (drain_en && pre > 0) begin
            if (q[0].trap) begin
                expXcpt = 1'b1;
                expCause = q[0].cause;
                void'(q.pop_front());
            end else begin
                for (int i = 0; i < CW; i++) begin
                    if (q.size() == 0 || q[0].trap) break;
                    expValid[i] = 1'b1;
                    expCheck[i] = q[0].chk;
                    expPc[i*XLEN +: XLEN] = q[0].pc;
                    expInst[i*IB +: IB] = q[0].inst;
                    expWdata[i*XLEN +: XLEN] = q[0].wdata;
                    expMstatus[i*XLEN +: XLEN] = q[0].mstatus;
                    void'(q.pop_front());
                end
            end
        end
        needed = int'(in_valid) + int'(in_trap);
        if (pre + needed > DEPTH) begin
            expOverflow = 1'b1;
        end else begin
            if (in_valid) begin
                e = '{trap: 1'b0, pc: in_pc, inst: in_inst, wdata: in_wdata,
                      mstatus: in_mstatus, chk: in_check, cause: '0};
                q.push_back(e);
            end
            if (in_trap) begin
                e = '{trap: 1'b1, pc: '0, inst: '0, wdata: '0, mstatus: '0, chk: 1'b0, cause: in_cause};
                q.push_back(e);
            end
        end
        expHart = in_hartid;
    endtask

    task automatic checkOutput();
        checkVal("valid", 128'(valid), 128'(expValid));
        checkVal("pc", 128'(pc), 128'(expPc));
        checkVal("inst", 128'(inst), 128'(expInst));
        checkVal("wdata", 128'(wdata), 128'(expWdata));
        checkVal("mstatus", 128'(mstatus), 128'(expMstatus));
        checkVal("check", 128'(check), 128'(expCheck));
        checkVal("int_xcpt", 128'(int_xcpt), 128'(expXcpt));
        checkVal("cause", 128'(cause), 128'(expCause));
        checkVal("overflow", 128'(overflow), 128'(expOverflow));
        checkVal("count", 128'(count), 128'(q.size()));
        checkVal("hartid", 128'(hartid), 128'(expHart));
`ifdef DIFFTEST_TRACE_STALL_EN
        checkVal("core_stall", 128'(core_stall), 128'(q.size() >= DEPTH - 3));
`endif
    endtask

    task automatic applyStimulus(input logic v, input logic [XLEN-1:0] p, input logic [IB-1:0] ins,
                                 input logic t, input logic [XLEN-1:0] c, input logic d);
        in_valid   = v;
        in_pc      = p;
        in_inst    = ins;
        in_trap    = t;
        in_cause   = c;
        drain_en   = d;
        in_wdata   = {$urandom, $urandom};
        in_mstatus = {$urandom, $urandom};
        in_check   = 1'($urandom);
        in_hartid  = HL'($urandom);
        @(posedge clock);
        modelStep();
        #1;
        checkOutput();
    endtask

    initial begin
        modelReset();
        #1;
        checkOutput();
        @(posedge clock);
        #1;
        checkOutput();
        #3 reset = 1'b0;

        // Single commit, visible two edges later, then idle.
        applyStimulus(1, 64'h8000_0000, 32'h0000_0013, 0, '0, 1);
        applyStimulus(0, '0, '0, 0, '0, 1);
        checkVal("plan_single_valid", 128'(valid), 128'(2'b01));
        checkVal("plan_single_pc", 128'(pc[XLEN-1:0]), 128'(64'h8000_0000));
        applyStimulus(0, '0, '0, 0, '0, 1);
        checkVal("plan_single_idle", 128'(valid), 128'(0));

        // Hold four commits, then drain as two full beats.
        for (int i = 0; i < 4; i++) applyStimulus(1, 64'h8000_1000 + 64'(4 * i), 32'h13, 0, '0, 0);
        checkVal("plan_count4", 128'(count), 128'(4));
        applyStimulus(0, '0, '0, 0, '0, 1);
        checkVal("plan_count2", 128'(count), 128'(2));
        checkVal("plan_beat1", 128'(valid), 128'(2'b11));
        applyStimulus(0, '0, '0, 0, '0, 1);
        checkVal("plan_count0", 128'(count), 128'(0));

        // Trap serialized behind older commits.
        applyStimulus(1, 64'hA0, 32'h1, 0, '0, 1);
        applyStimulus(1, 64'hB0, 32'h2, 0, '0, 1);
        applyStimulus(1, 64'hC0, 32'h3, 1, 64'h8000_0000_0000_0007, 1);
        applyStimulus(1, 64'hD0, 32'h4, 0, '0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, '0, '0, 0, '0, 1);

        // Nine commits into an eight-entry FIFO with draining held off.
        for (int i = 0; i < 9; i++) applyStimulus(1, 64'h9000 + 64'(4 * i), 32'h13, 0, '0, 0);
        checkVal("plan_overflow", 128'(overflow), 128'(1));
        checkVal("plan_full", 128'(count), 128'(DEPTH));
        for (int i = 0; i < 5; i++) applyStimulus(0, '0, '0, 0, '0, 1);

        // Asynchronous reset in the middle of draining.
        for (int i = 0; i < 7; i++) applyStimulus(1, 64'h7000 + 64'(4 * i), 32'h13, 0, '0, 0);
        applyStimulus(0, '0, '0, 0, '0, 1);
        checkVal("plan_count5", 128'(count), 128'(5));
        #2 reset = 1'b1;
        #1;
        modelReset();
        checkOutput();
        @(posedge clock);
        #1;
        checkOutput();
        #2 reset = 1'b0;
        applyStimulus(1, 64'h8000_2000, 32'h13, 0, '0, 1);
        applyStimulus(0, '0, '0, 0, '0, 1);
        checkVal("plan_post_reset_pc", 128'(pc[XLEN-1:0]), 128'(64'h8000_2000));

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom), {$urandom, $urandom}, $urandom, ($urandom_range(0, 4) == 0),
                          {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 10; i++) applyStimulus(0, '0, '0, 0, '0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
